// File: rtl/register_file_sb.sv
// Multi-port register file with a pending-write scoreboard for RAW hazard detection.
// Combinational reads with optional write forwarding; synchronous active-high reset.
module register_file_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WE,
    input  logic [ADDR_W-1:0]       RD,
    input  logic [DATA_W-1:0]       PD,
    input  logic                    RSV,
    input  logic [ADDR_W-1:0]       RSV_RD,
    input  logic [NRD*ADDR_W-1:0]   RA,
    output logic [NRD*DATA_W-1:0]   P,
    output logic [NRD-1:0]          BUSY,
    output logic [(2**ADDR_W)-1:0]  PEND
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              wr_ok;
    logic              rsv_ok;

    // Writes and reservations aimed at a hard-wired R0 are dropped entirely.
    always_comb begin
        wr_ok  = WE  && !((ZERO_R0 != 0) && (RD == '0));
        rsv_ok = RSV && !((ZERO_R0 != 0) && (RSV_RD == '0));
    end

    // The reservation is applied after the write-clear so a new producer wins.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_ok) begin
            regs_d[RD] = PD;
            pend_d[RD] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[RSV_RD] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign PEND = pend_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              fwd;
        logic [DATA_W-1:0] stored;

        assign ra     = RA[k*ADDR_W +: ADDR_W];
        assign fwd    = (BYPASS != 0) && wr_ok && (RD == ra);
        assign stored = ((ZERO_R0 != 0) && (ra == '0)) ? '0 : regs_q[ra];

        // A value being forwarded this cycle is available, so it never reports busy.
        assign P[k*DATA_W +: DATA_W] = fwd ? PD : stored;
        assign BUSY[k]               = pend_q[ra] && !fwd;
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two configurations (bypass/zero-R0/3 ports and
// no-bypass/plain-R0/2 ports) driven in lockstep, checked against array models.
module tb_register_file_sb;

    logic        CLK = 1'b0;
    logic        RST, WE, RSV;
    logic [4:0]  RD, RSV_RD;
    logic [31:0] PD;
    logic [14:0] RA_a;
    logic [9:0]  RA_b;
    logic [95:0] P_a;
    logic [63:0] P_b;
    logic [2:0]  BUSY_a;
    logic [1:0]  BUSY_b;
    logic [31:0] PEND_a, PEND_b;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    bit          pend_a [32];
    bit          pend_b [32];

    always #5 CLK = ~CLK;

    register_file_sb #(.DATA_W(32), .ADDR_W(5), .NRD(3), .BYPASS(1), .ZERO_R0(1)) dut_a (
        .CLK(CLK), .RST(RST), .WE(WE), .RD(RD), .PD(PD), .RSV(RSV), .RSV_RD(RSV_RD),
        .RA(RA_a), .P(P_a), .BUSY(BUSY_a), .PEND(PEND_a)
    );

    register_file_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_R0(0)) dut_b (
        .CLK(CLK), .RST(RST), .WE(WE), .RD(RD), .PD(PD), .RSV(RSV), .RSV_RD(RSV_RD),
        .RA(RA_b), .P(P_b), .BUSY(BUSY_b), .PEND(PEND_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Configuration A: forwarding on, R0 hard-wired to zero.
    function automatic bit fwd_a(input logic [4:0] ra);
        return WE && (RD != 5'd0) && (RD == ra);
    endfunction

    function automatic logic [31:0] exp_p_a(input logic [4:0] ra);
        if (fwd_a(ra)) return PD;
        if (ra == 5'd0) return 32'd0;
        return mem_a[ra];
    endfunction

    function automatic logic [31:0] pend_vec_a();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = pend_a[i];
        return v;
    endfunction

    function automatic logic [31:0] pend_vec_b();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = pend_b[i];
        return v;
    endfunction

    task automatic check_all();
        logic [4:0] ra;
        for (int k = 0; k < 3; k++) begin
            ra = RA_a[k*5 +: 5];
            check("a_p", {32'd0, P_a[k*32 +: 32]}, {32'd0, exp_p_a(ra)});
            check("a_busy", {63'd0, BUSY_a[k]}, {63'd0, pend_a[ra] && !fwd_a(ra)});
        end
        check("a_pend", {32'd0, PEND_a}, {32'd0, pend_vec_a()});
        // Configuration B has no forwarding: reads and busy reflect stored state only.
        for (int k = 0; k < 2; k++) begin
            ra = RA_b[k*5 +: 5];
            check("b_p", {32'd0, P_b[k*32 +: 32]}, {32'd0, mem_b[ra]});
            check("b_busy", {63'd0, BUSY_b[k]}, {63'd0, pend_b[ra]});
        end
        check("b_pend", {32'd0, PEND_b}, {32'd0, pend_vec_b()});
    endtask

    task automatic model_edge();
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i] = 32'd0; mem_b[i] = 32'd0;
                pend_a[i] = 1'b0; pend_b[i] = 1'b0;
            end
        end else begin
            if (WE && RD != 5'd0) begin
                mem_a[RD] = PD;
                pend_a[RD] = 1'b0;
            end
            if (RSV && RSV_RD != 5'd0) pend_a[RSV_RD] = 1'b1;
            if (WE) begin
                mem_b[RD] = PD;
                pend_b[RD] = 1'b0;
            end
            if (RSV) pend_b[RSV_RD] = 1'b1;
        end
    endtask

    // Inputs are set just after a falling edge; outputs are sampled before the rising edge.
    task automatic tick(input bit do_check);
        #1;
        if (do_check) check_all();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic set_ra_all(input logic [4:0] a);
        RA_a = {3{a}};
        RA_b = {2{a}};
    endtask

    initial begin
        RST = 1'b1; WE = 1'b0; RSV = 1'b0; RD = '0; RSV_RD = '0; PD = '0;
        set_ra_all(5'd0);
        @(negedge CLK);
        tick(1'b0);
        RST = 1'b0;
        #1;
        check("rst_p", {32'd0, P_a[31:0]}, 64'd0);
        check("rst_pend", {32'd0, PEND_a}, 64'd0);
        check("rst_busy", {61'd0, BUSY_a}, 64'd0);

        // Reset after writing R5 clears it.
        WE = 1'b1; RD = 5'd5; PD = 32'hDEAD;
        tick(1'b1);
        WE = 1'b0; RST = 1'b1; set_ra_all(5'd5);
        tick(1'b1);
        RST = 1'b0;
        #1;
        check("t1_p_a", {32'd0, P_a[31:0]}, 64'd0);
        check("t1_p_b", {32'd0, P_b[31:0]}, 64'd0);
        check("t1_pend", {32'd0, PEND_a}, 64'd0);
        check("t1_busy", {61'd0, BUSY_a}, 64'd0);

        // Same-cycle forward versus next-cycle visibility.
        WE = 1'b1; RD = 5'd7; PD = 32'h1234_5678; set_ra_all(5'd7);
        #1;
        check("t2_bypass", {32'd0, P_a[31:0]}, 64'h1234_5678);
        check("t2_old", {32'd0, P_b[31:0]}, 64'd0);
        tick(1'b1);
        WE = 1'b0;
        #1;
        check("t2_new", {32'd0, P_b[31:0]}, 64'h1234_5678);

        // Write and reserve of R0.
        WE = 1'b1; RD = 5'd0; PD = 32'hFFFF_FFFF; RSV = 1'b1; RSV_RD = 5'd0; set_ra_all(5'd0);
        tick(1'b1);
        WE = 1'b0; RSV = 1'b0;
        #1;
        check("t3_p_zero", {32'd0, P_a[31:0]}, 64'd0);
        check("t3_pend0_zero", {63'd0, PEND_a[0]}, 64'd0);
        check("t3_p_plain", {32'd0, P_b[31:0]}, 64'hFFFF_FFFF);
        check("t3_pend0_plain", {63'd0, PEND_b[0]}, 64'd1);
        tick(1'b1);

        // Reserve, busy, then forward clears busy in the writing cycle.
        RSV = 1'b1; RSV_RD = 5'd3;
        tick(1'b1);
        RSV = 1'b0; set_ra_all(5'd3);
        #1;
        check("t4_busy", {63'd0, BUSY_a[1]}, 64'd1);
        check("t4_pend", {63'd0, PEND_a[3]}, 64'd1);
        WE = 1'b1; RD = 5'd3; PD = 32'd9;
        #1;
        check("t4_fwd_busy", {63'd0, BUSY_a[1]}, 64'd0);
        check("t4_fwd_p", {32'd0, P_a[63:32]}, 64'd9);
        check("t4_nofwd_busy", {63'd0, BUSY_b[1]}, 64'd1);
        tick(1'b1);
        WE = 1'b0;
        #1;
        check("t4_pend_clr", {63'd0, PEND_a[3]}, 64'd0);
        check("t4_busy_clr", {63'd0, BUSY_a[1]}, 64'd0);

        // Write and reserve hitting the same register: reservation wins.
        WE = 1'b1; RD = 5'd4; PD = 32'hCAFE_0004; RSV = 1'b1; RSV_RD = 5'd4;
        tick(1'b1);
        WE = 1'b0; RSV = 1'b0; set_ra_all(5'd4);
        #1;
        check("t5_pend", {63'd0, PEND_a[4]}, 64'd1);
        check("t5_busy", {63'd0, BUSY_a[0]}, 64'd1);
        check("t5_data", {32'd0, P_a[31:0]}, 64'hCAFE_0004);
        tick(1'b1);

        // Three ports on one address, then reset beats a write.
        WE = 1'b1; RD = 5'd12; PD = 32'hA5A5_A5A5;
        tick(1'b1);
        WE = 1'b0; set_ra_all(5'd12);
        #1;
        check("t6_p0", {32'd0, P_a[31:0]}, 64'hA5A5_A5A5);
        check("t6_p1", {32'd0, P_a[63:32]}, 64'hA5A5_A5A5);
        check("t6_p2", {32'd0, P_a[95:64]}, 64'hA5A5_A5A5);
        RST = 1'b1; WE = 1'b1; RD = 5'd12; PD = 32'h1111_1111;
        tick(1'b1);
        RST = 1'b0; WE = 1'b0;
        #1;
        check("t6_rst_p", {32'd0, P_a[31:0]}, 64'd0);
        check("t6_rst_pend", {32'd0, PEND_a}, 64'd0);
        tick(1'b1);

        // Random traffic, biased so reads often collide with the write address.
        for (int n = 0; n < 400; n++) begin
            RST    = ($urandom_range(0, 39) == 0);
            WE     = $urandom_range(0, 1);
            RSV    = $urandom_range(0, 1);
            RD     = 5'($urandom_range(0, 7));
            RSV_RD = 5'($urandom_range(0, 7));
            PD     = $urandom;
            for (int k = 0; k < 3; k++)
                RA_a[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? RD : 5'($urandom_range(0, 7));
            for (int k = 0; k < 2; k++)
                RA_b[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? RD : 5'($urandom_range(0, 7));
            tick(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
